sram_writer: RTL and testbench

SRAM_WRITER -- requirements
Module: sram_writer

---
 rtl/sram_writer.sv | 156 +++++++++++++++
 tb/tb_sram_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_writer                                                     |
// | Purpose  : Queues write requests in a small FIFO and replays each one as an |
// |            async-SRAM write cycle. Optional read-back check is enabled by  |
// |            defining SRAM_WRITE_VERIFY_EN.                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_writer #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_valid,
  input  logic [19:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic        busy,
  output logic        done_w,
  output logic        verify_err,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    VREAD  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [35:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [19:0]        r_addr;
  logic [15:0]        r_data;
  logic               r_cnt;
  logic               w_push;
  logic               w_pop;
  logic               w_drive;

  assign wr_ready = (r_count != c_FULL);
  assign w_push   = wr_valid && wr_ready;
  assign busy     = (r_count != '0) || (r_state != IDLE);

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        {r_addr, r_data} <= r_mem[r_rptr];
      end
      // Shared two-cycle timer for STROBE and VREAD
      if ((r_state == STROBE) || (r_state == VREAD)) begin
        r_cnt <= ~r_cnt;
      end else begin
        r_cnt <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = SETUP;
        end
      end
      SETUP:  w_next = STROBE;
      STROBE: if (r_cnt) w_next = HOLD;
`ifdef SRAM_WRITE_VERIFY_EN
      HOLD:   w_next = VREAD;
`else
      HOLD:   w_next = DONE;
`endif
      VREAD:  if (r_cnt) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign CE      = 1'b0;
  assign UB      = 1'b0;
  assign LB      = 1'b0;
  assign WE      = (r_state != STROBE);
  assign done_w  = (r_state == DONE);
  assign ADDR    = r_addr;
  assign w_drive = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);
  assign Data    = w_drive ? r_data : 16'bz;

`ifdef SRAM_WRITE_VERIFY_EN
  logic r_verify_err;
  logic w_mismatch;

  // Bus is sampled in the second read cycle, once the SRAM output has settled
  assign w_mismatch = (r_state == VREAD) && r_cnt && (Data != r_data);
  assign verify_err = r_verify_err || w_mismatch;
  assign OE         = (r_state != VREAD);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_verify_err <= 1'b0;
    end else if (w_mismatch) begin
      r_verify_err <= 1'b1;
    end
  end
`else
  assign verify_err = 1'b0;
  assign OE         = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_writer                                                  |
// | Purpose  : Directed self-checking bench for sram_writer (both builds).     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sram_writer;

  // Pull-ups make a floating bus read as all ones
  localparam logic [15:0] c_BUS_FLOAT = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_valid;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done_w;
  logic        verify_err;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  logic [15:0] last_wr = 16'h0000;
  wire  [15:0] rd_word = (last_wr == 16'hA5A5) ? 16'h0000 : last_wr;

  int   n_checks = 0;
  int   n_pass = 0;
  logic in_write = 1'b0;
  logic model_err = 1'b0;

  sram_writer #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done_w(done_w),
    .verify_err(verify_err), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .ADDR(ADDR), .Data(Data)
  );

  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (Data[i]);
  end

  // SRAM model: stores the word on the WE rising edge; a faulty cell returns 0 for A5A5
  assign Data = (OE == 1'b0) ? rd_word : 16'bz;
  always @(posedge WE) if (Reset) last_wr <= Data;

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [19:0] a, input logic [15:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
    chk("push_busy", 32'(busy), 32'd1);
  endtask

  // Starts on the pop edge and ends one cycle into the following IDLE
  task automatic write_cycle(input logic [19:0] a, input logic [15:0] d);
    in_write = 1'b1;
    tick();
    chk("setup_we", 32'(WE), 32'd1);
    chk("setup_addr", 32'(ADDR), 32'(a));
    chk("setup_data", 32'(Data), 32'(d));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("strobe_we", 32'(WE), 32'd0);
      chk("strobe_oe", 32'(OE), 32'd1);
      chk("strobe_addr", 32'(ADDR), 32'(a));
      chk("strobe_data", 32'(Data), 32'(d));
      chk("strobe_done", 32'(done_w), 32'd0);
    end
    tick();
    chk("hold_we", 32'(WE), 32'd1);
    chk("hold_addr", 32'(ADDR), 32'(a));
    chk("hold_data", 32'(Data), 32'(d));
    chk("hold_done", 32'(done_w), 32'd0);
`ifdef SRAM_WRITE_VERIFY_EN
    tick();
    chk("vread1_oe", 32'(OE), 32'd0);
    chk("vread1_we", 32'(WE), 32'd1);
    chk("vread1_err", 32'(verify_err), 32'(model_err));
    if (d == 16'hA5A5) model_err = 1'b1;
    tick();
    chk("vread2_oe", 32'(OE), 32'd0);
    chk("vread2_bus", 32'(Data), 32'((d == 16'hA5A5) ? 16'h0000 : d));
    chk("vread2_err", 32'(verify_err), 32'(model_err));
    chk("vread_done", 32'(done_w), 32'd0);
`endif
    tick();
    chk("done_pulse", 32'(done_w), 32'd1);
    chk("done_we", 32'(WE), 32'd1);
    chk("done_bus", 32'(Data), 32'(c_BUS_FLOAT));
    chk("done_addr", 32'(ADDR), 32'(a));
    chk("done_err", 32'(verify_err), 32'(model_err));
    tick();
    chk("idle_done", 32'(done_w), 32'd0);
    chk("idle_addr", 32'(ADDR), 32'(a));
    in_write = 1'b0;
  endtask

  always @(negedge Clk) begin
    chk("we_oe_excl", 32'(WE | OE), 32'd1);
    chk("ce_ub_lb", 32'({CE, UB, LB}), 32'd0);
    chk("no_dropped_addr", 32'(ADDR == 20'hDEAD0), 32'd0);
    if (!in_write) chk("bus_idle", 32'(Data), 32'(c_BUS_FLOAT));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    #2 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_we", 32'(WE), 32'd1);
    chk("rst_oe", 32'(OE), 32'd1);
    chk("rst_bus", 32'(Data), 32'(c_BUS_FLOAT));
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_done", 32'(done_w), 32'd0);
    chk("rst_verr", 32'(verify_err), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    Reset = 1'b1;

    // Single write from reset
    push(20'h00010, 16'hBEEF);
    write_cycle(20'h00010, 16'hBEEF);
    chk("single_busy", 32'(busy), 32'd0);

    // Fill the FIFO while a write is in flight; the fifth request is dropped
    push(20'h00100, 16'h1111);
    fork
      write_cycle(20'h00100, 16'h1111);
      begin
        tick();
        for (int i = 0; i < 4; i++) begin
          wr_valid = 1'b1;
          wr_addr = 20'(20'h00200 + i);
          wr_data = 16'(16'h2000 + i);
          tick();
          chk("fill_ready", 32'(wr_ready), 32'(i < 3));
        end
        wr_addr = 20'hDEAD0; wr_data = 16'hDEAD;
        tick();
        chk("drop_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
      end
    join
    for (int i = 0; i < 4; i++) write_cycle(20'(20'h00200 + i), 16'(16'h2000 + i));
    chk("fill_drained", 32'(busy), 32'd0);

    // Simultaneous push and pop at count 3
    push(20'h00300, 16'h3000);
    fork
      write_cycle(20'h00300, 16'h3000);
      begin
        tick();
        for (int i = 1; i < 4; i++) begin
          wr_valid = 1'b1;
          wr_addr = 20'(20'h00300 + i);
          wr_data = 16'(16'h3000 + i);
          tick();
        end
        wr_valid = 1'b0;
      end
    join
    chk("cnt3_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_addr = 20'h00304; wr_data = 16'h3004;
    fork
      write_cycle(20'h00301, 16'h3001);
      begin
        tick();
        chk("pushpop_ready", 32'(wr_ready), 32'd1);
        wr_addr = 20'h00305; wr_data = 16'h3005;
        tick();
        wr_valid = 1'b0;
        chk("pushpop_full", 32'(wr_ready), 32'd0);
      end
    join
    for (int i = 2; i < 6; i++) write_cycle(20'(20'h00300 + i), 16'(16'h3000 + i));
    chk("pushpop_drained", 32'(busy), 32'd0);

    // Reset in the middle of STROBE with a second request queued
    in_write = 1'b1;
    wr_valid = 1'b1; wr_addr = 20'h00400; wr_data = 16'h4444;
    tick();
    wr_addr = 20'h00401; wr_data = 16'h4445;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("pre_abort_we", 32'(WE), 32'd0);
    #2 Reset = 1'b0;
    #1;
    chk("abort_we", 32'(WE), 32'd1);
    chk("abort_bus", 32'(Data), 32'(c_BUS_FLOAT));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done_w), 32'd0);
    chk("abort_ready", 32'(wr_ready), 32'd1);
    chk("abort_addr", 32'(ADDR), 32'd0);
    in_write = 1'b0;
    @(posedge Clk);
    #3 Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_done", 32'(done_w), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    push(20'h00500, 16'h1234);
    write_cycle(20'h00500, 16'h1234);

`ifdef SRAM_WRITE_VERIFY_EN
    // Faulty read-back sets the sticky flag; later good writes leave it set
    push(20'h00600, 16'hA5A5);
    write_cycle(20'h00600, 16'hA5A5);
    chk("verr_set", 32'(verify_err), 32'd1);
    for (int i = 1; i < 4; i++) begin
      push(20'(20'h00600 + i), 16'(16'h5A50 + i));
      write_cycle(20'(20'h00600 + i), 16'(16'h5A50 + i));
    end
    chk("verr_sticky", 32'(verify_err), 32'd1);
`else
    chk("verr_tied", 32'(verify_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
